// File: rtl/bool_tt_pkg.sv
// Shared definitions for the truth-table sequencer: state encoding, table width helper
// and the default 3-input majority table.
package bool_tt_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StDrive = ST_DRIVE,
    StDone  = ST_DONE
  } tt_state_e;

  // Majority of a, b, c with a as bit 0 of the vector index.
  localparam logic [7:0] TT_MAJ3 = 8'hE8;

  // Number of rows in a truth table over n inputs.
  function automatic int unsigned TT_W(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
module settle_timer
  import bool_tt_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bool_tt_checker.sv
// Truth-table sequencer: walks every input vector of a combinational stage, holds each
// for SETTLE cycles, samples the stage output and compares it to an expected table.
module bool_tt_checker
  import bool_tt_pkg::*;
#(
  parameter int unsigned               N_IN     = 3,
  parameter int unsigned               SETTLE   = 2,
  parameter logic [TT_W(N_IN)-1:0]     EXPECTED = TT_MAJ3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [N_IN-1:0]       dut_in,
  input  logic                  dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [TT_W(N_IN)-1:0] captured,
  output logic [TT_W(N_IN)-1:0] mismatch
);

  localparam int unsigned   NV     = TT_W(N_IN);
  localparam int unsigned   CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST = N_IN'(NV - 1);

  tt_state_e       state_q;
  logic [N_IN-1:0] idx_q;
  logic            start_ok;
  logic            in_drive;
  logic            at_last;
  logic            tmr_zero;
  logic            tmr_load;
  logic            tmr_dec;
  logic [NV-1:0]   mismatch_upd;

  // Start is honoured only when no run is in progress.
  always_comb begin
    start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    in_drive = (state_q == StDrive);
    at_last  = (idx_q == LAST);
    tmr_load = start_ok || (in_drive && tmr_zero && !at_last);
    tmr_dec  = in_drive && !tmr_zero;
  end

  // Mismatch vector including the bit written this edge, so pass sees the final result.
  always_comb begin
    mismatch_upd        = mismatch;
    mismatch_upd[idx_q] = dut_out ^ EXPECTED[idx_q];
  end

  settle_timer #(
    .WIDTH (CW)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (RELOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Sequencer FSM with registered outputs; the index stops at the last vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      dut_in   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      captured <= '0;
      mismatch <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_ok) begin
            state_q  <= StDrive;
            idx_q    <= '0;
            dut_in   <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            captured <= '0;
            mismatch <= '0;
          end
        end
        StDrive: begin
          if (tmr_zero) begin
            captured[idx_q] <= dut_out;
            mismatch        <= mismatch_upd;
            if (at_last) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= ~|mismatch_upd;
            end else begin
              idx_q  <= idx_q + 1'b1;
              dut_in <= idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
